vdm_mctp_mailbox: RTL and testbench
===================================

Name: vdm_mctp_mailbox

Overview:
- Multi-channel, CSR-mapped MCTP-over-PCIe-VDM transmit mailbox.
- Host software fills a per-channel DWORD FIFO through a data register, then commits the packet through a FIFO control register.
- A round-robin arbiter streams committed packets, one at a time, to the PMCI/ST2MM VDM egress path on a valid/ready stream, tagged with the channel id.
- Sits behind the PMCI/ST2MM feature CSR decoder.

Parameters:
- NUM_CH, 2, number of independent mailbox channels (1..8).
- DEPTH_DW, 64, per-channel FIFO depth in 32-bit DWORDs; power of 2, 16..1024.
- CH_STRIDE, 16, byte stride between channel register pairs.
- CNT_W, $clog2(DEPTH_DW+1), fill-count width (derived, not overridable).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_write  in  1  single-cycle write strobe
- csr_read  in  1  single-cycle read strobe
- csr_addr  in  12  byte address relative to block base; 8-byte aligned
- csr_wdata  in  64  write data
- csr_rdata  out  64  read data
- csr_rvalid  out  1  read data valid
- vdm_tvalid  out  1  egress DWORD valid
- vdm_tready  in  1  egress ready
- vdm_tdata  out  32  egress DWORD
- vdm_tlast  out  1  last DWORD of the packet
- vdm_tuser  out  3  source channel id
- irq_done  out  1  one-cycle pulse when a packet's final beat is accepted

Behaviour:
- Address decode:
  - ch = addr / CH_STRIDE.
  - FCR at ch*CH_STRIDE + 0x0; DR at ch*CH_STRIDE + 0x8.
  - Any ch >= NUM_CH or any other offset: reads return 0, writes are ignored.
- FCR fields:
  - [0] COMMIT: W1, self-clearing.
  - [1] FLUSH: W1, self-clearing.
  - [2] READY: RO; packet committed, awaiting transmit.
  - [3] BUSY: RO; channel currently transmitting.
  - [4] OVF: sticky, W1C.
  - [5] EMPTY: RO.
  - [6] FULL: RO.
  - [31:16] fill count: RO, zero-extended from CNT_W.
  - All other bits read 0.
- DR write:
  - Pushes csr_wdata[31:0] into that channel's FIFO.
  - Dropped, with OVF set, if FULL, READY or BUSY.
  - DR reads return 0.
- COMMIT:
  - Fill > 0 and not READY/BUSY: set READY; packet length = fill count.
  - Fill == 0: set OVF, READY unchanged.
  - Already READY or BUSY: ignored.
- FLUSH:
  - Not BUSY: empty the FIFO and clear READY.
  - BUSY: ignored.
  - FLUSH and COMMIT in the same write: FLUSH wins, no commit.
- Arbiter:
  - Idle state: select the lowest READY channel at or after last_grant+1, modulo NUM_CH.
  - On grant, next cycle: that channel's READY->0, BUSY->1, state SEND.
  - SEND: vdm_tdata = FIFO head. Pop on tvalid && tready. tlast asserted while fill == 1.
  - Final beat accepted: BUSY->0, irq_done pulses for 1 cycle, state IDLE. No bubble needed before the next grant evaluation.
  - tvalid, tdata, tuser and tlast are held stable while tvalid && !tready.
- CSR read:
  - Registered; csr_rvalid asserts exactly 1 cycle after csr_read.
  - Reflects state at the cycle of the read strobe.
- Simultaneous csr_write and csr_read: both are serviced.
- DR push to a BUSY channel in the same cycle as a pop: dropped with OVF set; count changes only by the pop.
- Reset (asynchronous):
  - All FIFOs empty; all READY, BUSY and OVF = 0.
  - Arbiter IDLE, last_grant = NUM_CH-1.
  - vdm_tvalid = 0, vdm_tlast = 0, vdm_tdata = 0, vdm_tuser = 0.
  - csr_rdata = 0, csr_rvalid = 0, irq_done = 0.
  - Reset mid-packet abandons the packet; no tlast is emitted.
- Pointers wrap modulo DEPTH_DW. Count is CNT_W bits, so full = DEPTH_DW is representable.

Decomposition:
- Package vdm_mctp_mailbox_pkg:
  - FCR/DR offsets.
  - FCR bit-position localparams.
  - Arbiter state enum {IDLE, SEND}.
  - Channel-id width constant.
- Sub-module vdm_ch_fifo (one instance per channel via generate):
  - Ports: push, pop, data, count, full, empty, flush.
  - Synchronous-read storage with show-ahead head register.
- Top level holds CSR decode, per-channel control flags, round-robin arbiter and stream output.

Test Plan:
1. Write 4 DWs 0xA0..0xA3 to ch0 DR, COMMIT -> FCR count=4 READY=1 before grant; stream emits A0..A3 with tuser=0, tlast on A3, irq_done one pulse; FCR then EMPTY=1.
2. Fill ch1 with DEPTH_DW DWs plus one extra -> FULL=1, count=64, OVF=1. W1C OVF -> OVF=0, data intact; commit and drain 64 beats.
3. Commit 3-DW packets on ch0 and ch1 in the same cycle, vdm_tready toggled 1/0 each cycle -> ch0 packet first, then ch1; data held stable while stalled.
4. COMMIT on an empty channel -> OVF=1, READY=0, no stream activity. FLUSH while BUSY -> ignored, packet completes.
5. Assert rst_n low during beat 2 of a 5-beat packet -> tvalid drops immediately, all counts 0. After release, a new 2-DW packet transmits correctly.
6. Read FCR of ch=NUM_CH and an unmapped offset -> rdata=0 with rvalid 1 cycle later; writes there change nothing.

Source files
------------

// File: rtl/vdm_mctp_mailbox_pkg.sv
// Shared constants for the MCTP-over-VDM transmit mailbox: register map,
// FCR bit positions and arbiter state encoding.
package vdm_mctp_mailbox_pkg;

  localparam int FCR_OFS = 0;
  localparam int DR_OFS  = 8;

  localparam int FCR_COMMIT  = 0;
  localparam int FCR_FLUSH   = 1;
  localparam int FCR_READY   = 2;
  localparam int FCR_BUSY    = 3;
  localparam int FCR_OVF     = 4;
  localparam int FCR_EMPTY   = 5;
  localparam int FCR_FULL    = 6;
  localparam int FCR_CNT_LSB = 16;

  localparam int CH_ID_W = 3;

  typedef enum logic {ARB_IDLE, ARB_SEND} arb_state_t;

endpackage

// File: rtl/vdm_ch_fifo.sv
// Per-channel DWORD FIFO: synchronous-read RAM with a show-ahead head register
// that always holds the entry at the (next) read pointer.
module vdm_ch_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH_DW = 64,
  localparam int CNT_W   = $clog2(DEPTH_DW + 1),
  localparam int AW      = $clog2(DEPTH_DW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH_DW];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic              push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH_DW));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    rd_ptr_nxt = rd_ptr + AW'(pop_ok);
    if (flush) rd_ptr_nxt = '0;
  end

  // Storage and head register; a push landing on the next read slot is bypassed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data;
    head <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? data : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr_nxt;
      count  <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/vdm_mctp_mailbox.sv
// CSR-mapped multi-channel MCTP transmit mailbox: host fills per-channel FIFOs,
// commits packets, and a round-robin arbiter streams them to the VDM egress.
module vdm_mctp_mailbox
  import vdm_mctp_mailbox_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DEPTH_DW  = 64,
  parameter int CH_STRIDE = 16,
  localparam int CNT_W    = $clog2(DEPTH_DW + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_write,
  input  logic               csr_read,
  input  logic [11:0]        csr_addr,
  input  logic [63:0]        csr_wdata,
  output logic [63:0]        csr_rdata,
  output logic               csr_rvalid,
  output logic               vdm_tvalid,
  input  logic               vdm_tready,
  output logic [31:0]        vdm_tdata,
  output logic               vdm_tlast,
  output logic [CH_ID_W-1:0] vdm_tuser,
  output logic               irq_done
);

  logic [11:0]        ch_idx, ofs;
  logic               addr_hit, is_fcr, is_dr;
  logic [NUM_CH-1:0]  sel, wr_fcr, wr_dr;
  logic [NUM_CH-1:0]  ready, busy, ovf, full, empty;
  logic [NUM_CH-1:0]  push, drop, flush, commit_ok, commit_bad, ovf_clr, pop, elig;
  logic [31:0]        head [NUM_CH];
  logic [CNT_W-1:0]   cnt  [NUM_CH];
  arb_state_t         state_q, state_d;
  logic [CH_ID_W-1:0] last_grant, cur_ch, grant_ch;
  logic               grant_vld, grant_fire, send, beat, last_acc;
  logic [31:0]        cur_head;
  logic [CNT_W-1:0]   cur_cnt;
  logic [63:0]        rd_val_p0;
  logic               unused_wdata;

  assign unused_wdata = ^csr_wdata[63:32];

  assign ch_idx   = csr_addr / 12'(CH_STRIDE);
  assign ofs      = csr_addr % 12'(CH_STRIDE);
  assign addr_hit = ch_idx < 12'(NUM_CH);
  assign is_fcr   = addr_hit && (ofs == 12'(FCR_OFS));
  assign is_dr    = addr_hit && (ofs == 12'(DR_OFS));
  assign wr_fcr   = {NUM_CH{csr_write && is_fcr}} & sel;
  assign wr_dr    = {NUM_CH{csr_write && is_dr}} & sel;

  always_comb begin
    sel = '0; push = '0; drop = '0; flush = '0; commit_ok = '0;
    commit_bad = '0; ovf_clr = '0; pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]     = (ch_idx == 12'(c));
      push[c]    = wr_dr[c] && !full[c] && !ready[c] && !busy[c];
      drop[c]    = wr_dr[c] && (full[c] || ready[c] || busy[c]);
      flush[c]   = wr_fcr[c] && csr_wdata[FCR_FLUSH] && !busy[c];
      ovf_clr[c] = wr_fcr[c] && csr_wdata[FCR_OVF];
      if (wr_fcr[c] && csr_wdata[FCR_COMMIT] && !csr_wdata[FCR_FLUSH] && !ready[c] && !busy[c]) begin
        commit_ok[c]  = (cnt[c] != '0);
        commit_bad[c] = (cnt[c] == '0);
      end
      pop[c] = beat && (cur_ch == CH_ID_W'(c));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    vdm_ch_fifo #(.DATA_W(32), .DEPTH_DW(DEPTH_DW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .flush (flush[g]),
      .data  (csr_wdata[31:0]),
      .head  (head[g]),
      .count (cnt[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // A channel being flushed this cycle must not be granted.
  assign elig = ready & ~flush;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = last_grant;
    for (int i = 1; i <= NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_vld && (c == (int'(last_grant) + i) % NUM_CH) && elig[c]) begin
          grant_vld = 1'b1;
          grant_ch  = CH_ID_W'(c);
        end
      end
    end
  end

  always_comb begin
    cur_head = '0;
    cur_cnt  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_ch == CH_ID_W'(c)) begin
        cur_head = head[c];
        cur_cnt  = cnt[c];
      end
    end
  end

  assign send       = (state_q == ARB_SEND);
  assign grant_fire = (state_q == ARB_IDLE) && grant_vld;
  assign vdm_tvalid = send;
  assign vdm_tdata  = send ? cur_head : '0;
  assign vdm_tlast  = send && (cur_cnt == CNT_W'(1));
  assign vdm_tuser  = send ? cur_ch : '0;
  assign beat       = send && vdm_tready;
  assign last_acc   = beat && vdm_tlast;
  assign irq_done   = last_acc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant_vld) state_d = ARB_SEND;
      ARB_SEND: if (last_acc)  state_d = ARB_IDLE;
      default:                 state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      last_grant <= CH_ID_W'(NUM_CH - 1);
      cur_ch     <= '0;
      ready      <= '0;
      busy       <= '0;
      ovf        <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) cur_ch <= grant_ch;
      if (last_acc) last_grant <= cur_ch;
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush[c])                                            ready[c] <= 1'b0;
        else if (commit_ok[c])                                   ready[c] <= 1'b1;
        else if (grant_fire && (grant_ch == CH_ID_W'(c)))        ready[c] <= 1'b0;
        if (grant_fire && (grant_ch == CH_ID_W'(c)))             busy[c]  <= 1'b1;
        else if (last_acc && (cur_ch == CH_ID_W'(c)))            busy[c]  <= 1'b0;
        ovf[c] <= (ovf[c] & ~ovf_clr[c]) | drop[c] | commit_bad[c];
      end
    end
  end

  always_comb begin
    rd_val_p0 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (csr_read && is_fcr && sel[c]) begin
        rd_val_p0[FCR_READY]             = ready[c];
        rd_val_p0[FCR_BUSY]              = busy[c];
        rd_val_p0[FCR_OVF]               = ovf[c];
        rd_val_p0[FCR_EMPTY]             = empty[c];
        rd_val_p0[FCR_FULL]              = full[c];
        rd_val_p0[FCR_CNT_LSB +: 16]     = 16'(cnt[c]);
      end
    end
  end

  // p0 -> p1: registered read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rvalid <= 1'b0;
      csr_rdata  <= '0;
    end else begin
      csr_rvalid <= csr_read;
      csr_rdata  <= rd_val_p0;
    end
  end

endmodule

// File: tb/tb_vdm_mctp_mailbox.sv
// Directed self-checking bench for vdm_mctp_mailbox (NUM_CH=2, DEPTH_DW=64).
module tb_vdm_mctp_mailbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_write = 1'b0, csr_read = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic [63:0] csr_rdata;
  logic        csr_rvalid;
  logic        vdm_tvalid, vdm_tready = 1'b0, vdm_tlast, irq_done;
  logic [31:0] vdm_tdata;
  logic [2:0]  vdm_tuser;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vdm_mctp_mailbox #(.NUM_CH(2), .DEPTH_DW(64), .CH_STRIDE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_write(csr_write), .csr_read(csr_read), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .vdm_tvalid(vdm_tvalid), .vdm_tready(vdm_tready), .vdm_tdata(vdm_tdata),
    .vdm_tlast(vdm_tlast), .vdm_tuser(vdm_tuser), .irq_done(irq_done)
  );

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    csr_write = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_write = 1'b0; csr_wdata = '0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [63:0] d, output logic v);
    csr_read = 1'b1; csr_addr = a;
    @(negedge clk);
    csr_read = 1'b0;
    #1;
    d = csr_rdata; v = csr_rvalid;
  endtask

  task automatic test_reset;
    logic [63:0] d; logic v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (vdm_tvalid !== 1'b0 || vdm_tlast !== 1'b0 || vdm_tdata !== 32'h0 || vdm_tuser !== 3'd0 ||
        csr_rdata !== 64'h0 || csr_rvalid !== 1'b0 || irq_done !== 1'b0) begin
      $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h tuser=%0d rdata=%h rvalid=%b irq=%b, want all 0",
               vdm_tvalid, vdm_tlast, vdm_tdata, vdm_tuser, csr_rdata, csr_rvalid, irq_done);
      n_err++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    csr_rd(12'h000, d, v);
    n_vec++;
    if (d !== 64'h20 || v !== 1'b1) begin
      $display("FAIL reset_fcr0: rdata=%h rvalid=%b, want 20 / 1", d, v); n_err++;
    end
  endtask

  task automatic test_basic;
    logic [63:0] d; logic v;
    for (int i = 0; i < 4; i++) csr_wr(12'h008, 64'(32'hA0 + i));
    csr_wr(12'h000, 64'h1);
    csr_rd(12'h000, d, v);
    n_vec++;
    if (d !== 64'h0004_0004 || v !== 1'b1) begin
      $display("FAIL basic_ready: rdata=%h rvalid=%b, want 40004 / 1", d, v); n_err++;
    end
    for (int k = 0; k < 4; k++) begin
      vdm_tready = 1'b1; #1;
      n_vec++;
      if (vdm_tvalid !== 1'b1 || vdm_tdata !== 32'hA0 + k || vdm_tuser !== 3'd0 ||
          vdm_tlast !== (k == 3) || irq_done !== (k == 3)) begin
        $display("FAIL basic_beat%0d: v=%b d=%h u=%0d l=%b irq=%b, want 1 %h 0 %b %b",
                 k, vdm_tvalid, vdm_tdata, vdm_tuser, vdm_tlast, irq_done, 32'hA0 + k, k == 3, k == 3);
        n_err++;
      end
      @(negedge clk);
    end
    vdm_tready = 1'b0; #1;
    n_vec++;
    if (vdm_tvalid !== 1'b0 || irq_done !== 1'b0) begin
      $display("FAIL basic_idle: tvalid=%b irq=%b, want 0 0", vdm_tvalid, irq_done); n_err++;
    end
    csr_rd(12'h000, d, v);
    n_vec++;
    if (d !== 64'h20) begin $display("FAIL basic_empty: rdata=%h, want 20", d); n_err++; end
  endtask

  task automatic test_full_ovf;
    logic [63:0] d; logic v; int t;
    for (int i = 0; i < 65; i++) csr_wr(12'h018, 64'(32'h100 + i));
    csr_rd(12'h010, d, v);
    n_vec++;
    if (d !== 64'h0040_0050) begin $display("FAIL full_fcr: rdata=%h, want 400050", d); n_err++; end
    csr_wr(12'h010, 64'h10);
    csr_rd(12'h010, d, v);
    n_vec++;
    if (d !== 64'h0040_0040) begin $display("FAIL full_w1c: rdata=%h, want 400040", d); n_err++; end
    csr_wr(12'h010, 64'h1);
    t = 0;
    while (!vdm_tvalid && t < 20) begin @(negedge clk); #1; t++; end
    n_vec++;
    if (vdm_tvalid !== 1'b1) begin $display("FAIL full_start: tvalid=%b, want 1", vdm_tvalid); n_err++; return; end
    for (int k = 0; k < 64; k++) begin
      vdm_tready = 1'b1; #1;
      n_vec++;
      if (vdm_tvalid !== 1'b1 || vdm_tdata !== 32'h100 + k || vdm_tuser !== 3'd1 || vdm_tlast !== (k == 63)) begin
        $display("FAIL full_beat%0d: v=%b d=%h u=%0d l=%b, want 1 %h 1 %b",
                 k, vdm_tvalid, vdm_tdata, vdm_tuser, vdm_tlast, 32'h100 + k, k == 63);
        n_err++;
      end
      @(negedge clk);
    end
    vdm_tready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [6];
    int idx, cyc, irqs;
    bit stalled, ph;
    logic [31:0] hd; logic hl; logic [2:0] hu;
    exp_d = '{32'hC0, 32'hC1, 32'hC2, 32'hD0, 32'hD1, 32'hD2};
    for (int i = 0; i < 3; i++) csr_wr(12'h008, 64'(32'hC0 + i));
    for (int i = 0; i < 3; i++) csr_wr(12'h018, 64'(32'hD0 + i));
    csr_wr(12'h000, 64'h1);
    csr_wr(12'h010, 64'h1);
    idx = 0; cyc = 0; irqs = 0; stalled = 0; ph = 1;
    while (idx < 6 && cyc < 60) begin
      vdm_tready = ph; #1;
      if (irq_done) irqs++;
      if (stalled) begin
        n_vec++;
        if (vdm_tvalid !== 1'b1 || vdm_tdata !== hd || vdm_tlast !== hl || vdm_tuser !== hu) begin
          $display("FAIL rr_hold%0d: v=%b d=%h l=%b u=%0d, want 1 %h %b %0d",
                   idx, vdm_tvalid, vdm_tdata, vdm_tlast, vdm_tuser, hd, hl, hu);
          n_err++;
        end
      end
      stalled = 0;
      if (vdm_tvalid && vdm_tready) begin
        n_vec++;
        if (vdm_tdata !== exp_d[idx] || vdm_tuser !== ((idx < 3) ? 3'd0 : 3'd1) ||
            vdm_tlast !== (idx == 2 || idx == 5)) begin
          $display("FAIL rr_beat%0d: d=%h u=%0d l=%b, want %h %0d %b",
                   idx, vdm_tdata, vdm_tuser, vdm_tlast, exp_d[idx], (idx < 3) ? 0 : 1, idx == 2 || idx == 5);
          n_err++;
        end
        idx++;
      end else if (vdm_tvalid) begin
        stalled = 1; hd = vdm_tdata; hl = vdm_tlast; hu = vdm_tuser;
      end
      ph = !ph; cyc++;
      @(negedge clk);
    end
    vdm_tready = 1'b0;
    n_vec++;
    if (idx != 6 || irqs != 2) begin
      $display("FAIL rr_total: beats=%0d irqs=%0d, want 6 2", idx, irqs); n_err++;
    end
  endtask

  task automatic test_empty_commit_flush_busy;
    logic [63:0] d; logic v; int t;
    csr_wr(12'h000, 64'h1);
    csr_rd(12'h000, d, v);
    n_vec++;
    if (d !== 64'h30) begin $display("FAIL empty_commit: rdata=%h, want 30", d); n_err++; end
    repeat (3) @(negedge clk);
    n_vec++;
    if (vdm_tvalid !== 1'b0) begin $display("FAIL empty_nostream: tvalid=%b, want 0", vdm_tvalid); n_err++; end
    csr_wr(12'h000, 64'h10);
    csr_wr(12'h008, 64'hE0);
    csr_wr(12'h008, 64'hE1);
    csr_wr(12'h000, 64'h1);
    t = 0;
    while (!vdm_tvalid && t < 20) begin @(negedge clk); #1; t++; end
    csr_wr(12'h000, 64'h2);
    csr_rd(12'h000, d, v);
    n_vec++;
    if (d !== 64'h0002_0008) begin $display("FAIL flush_busy: rdata=%h, want 20008", d); n_err++; end
    for (int k = 0; k < 2; k++) begin
      vdm_tready = 1'b1; #1;
      n_vec++;
      if (vdm_tvalid !== 1'b1 || vdm_tdata !== 32'hE0 + k || vdm_tlast !== (k == 1)) begin
        $display("FAIL flush_beat%0d: v=%b d=%h l=%b, want 1 %h %b", k, vdm_tvalid, vdm_tdata, vdm_tlast, 32'hE0 + k, k == 1);
        n_err++;
      end
      @(negedge clk);
    end
    vdm_tready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [63:0] d0, d1; logic v; int t;
    for (int i = 0; i < 5; i++) csr_wr(12'h018, 64'(32'h50 + i));
    csr_wr(12'h010, 64'h1);
    t = 0;
    while (!vdm_tvalid && t < 20) begin @(negedge clk); #1; t++; end
    vdm_tready = 1'b1; #1;
    n_vec++;
    if (vdm_tvalid !== 1'b1 || vdm_tdata !== 32'h50) begin
      $display("FAIL rst_beat0: v=%b d=%h, want 1 50", vdm_tvalid, vdm_tdata); n_err++;
    end
    @(negedge clk);
    rst_n = 1'b0; vdm_tready = 1'b0; #1;
    n_vec++;
    if (vdm_tvalid !== 1'b0 || vdm_tlast !== 1'b0 || vdm_tdata !== 32'h0 || irq_done !== 1'b0) begin
      $display("FAIL rst_drop: v=%b l=%b d=%h irq=%b, want 0 0 0 0", vdm_tvalid, vdm_tlast, vdm_tdata, irq_done);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    csr_rd(12'h000, d0, v);
    csr_rd(12'h010, d1, v);
    n_vec++;
    if (d0 !== 64'h20 || d1 !== 64'h20) begin
      $display("FAIL rst_counts: fcr0=%h fcr1=%h, want 20 20", d0, d1); n_err++;
    end
    csr_wr(12'h008, 64'h61);
    csr_wr(12'h008, 64'h62);
    csr_wr(12'h000, 64'h1);
    t = 0;
    while (!vdm_tvalid && t < 20) begin @(negedge clk); #1; t++; end
    for (int k = 0; k < 2; k++) begin
      vdm_tready = 1'b1; #1;
      n_vec++;
      if (vdm_tvalid !== 1'b1 || vdm_tdata !== 32'h61 + k || vdm_tuser !== 3'd0 || vdm_tlast !== (k == 1)) begin
        $display("FAIL rst_new%0d: v=%b d=%h u=%0d l=%b, want 1 %h 0 %b",
                 k, vdm_tvalid, vdm_tdata, vdm_tuser, vdm_tlast, 32'h61 + k, k == 1);
        n_err++;
      end
      @(negedge clk);
    end
    vdm_tready = 1'b0;
  endtask

  task automatic test_unmapped;
    logic [63:0] d, d0, d1; logic v;
    csr_rd(12'h020, d, v);
    n_vec++;
    if (d !== 64'h0 || v !== 1'b1) begin $display("FAIL unmap_ch2: rdata=%h rvalid=%b, want 0 1", d, v); n_err++; end
    csr_rd(12'h004, d, v);
    n_vec++;
    if (d !== 64'h0 || v !== 1'b1) begin $display("FAIL unmap_ofs: rdata=%h rvalid=%b, want 0 1", d, v); n_err++; end
    csr_wr(12'h020, 64'h1);
    csr_wr(12'h028, 64'h99);
    csr_wr(12'h004, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_rd(12'h000, d0, v);
    csr_rd(12'h010, d1, v);
    n_vec++;
    if (d0 !== 64'h20 || d1 !== 64'h20 || vdm_tvalid !== 1'b0) begin
      $display("FAIL unmap_wr: fcr0=%h fcr1=%h tvalid=%b, want 20 20 0", d0, d1, vdm_tvalid); n_err++;
    end
    csr_write = 1'b1; csr_read = 1'b1; csr_addr = 12'h008; csr_wdata = 64'h77;
    @(negedge clk);
    csr_write = 1'b0; csr_read = 1'b0; csr_wdata = '0; #1;
    n_vec++;
    if (csr_rdata !== 64'h0 || csr_rvalid !== 1'b1) begin
      $display("FAIL rdwr_dr: rdata=%h rvalid=%b, want 0 1", csr_rdata, csr_rvalid); n_err++;
    end
    csr_rd(12'h000, d, v);
    n_vec++;
    if (d !== 64'h0001_0000) begin $display("FAIL rdwr_push: rdata=%h, want 10000", d); n_err++; end
    csr_wr(12'h000, 64'h2);
    csr_rd(12'h000, d, v);
    n_vec++;
    if (d !== 64'h20) begin $display("FAIL flush_idle: rdata=%h, want 20", d); n_err++; end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_ovf;
    test_back_to_back;
    test_empty_commit_flush_busy;
    test_reset_mid;
    test_unmapped;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
